// File: rtl/deser_pkg.sv
// deser_pkg: shared states, frame defaults and line levels for the serial link
// Ports: none (package)
package deser_pkg;
    typedef enum logic [1:0] {HUNT, IDLE, DATA, STOP} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_WORDS = 8;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT = 1'b0;
    localparam logic LINE_IDLE = 1'b0;
endpackage

// File: rtl/deser_frame_ctrl.sv
// deser_frame_ctrl: framing FSM and bit/word counters for the deserializer
// Ports: clk/rst, serial_i, enable_i in; shift_en_o, load_o (good stop),
//        frame_err_o (registered pulse), busy_o, bit_count_o, word_count_o out
module deser_frame_ctrl
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int CW = $clog2(WIDTH),
    parameter int WW = $clog2(N_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_i,
    input  logic          enable_i,
    output logic          shift_en_o,
    output logic          load_o,
    output logic          frame_err_o,
    output logic          busy_o,
    output logic [CW-1:0] bit_count_o,
    output logic [WW-1:0] word_count_o
);
    state_t state_q, state_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [WW-1:0] word_q, word_d;
    logic frame_err_q;
    logic last_bit, last_word;

    assign last_bit = bit_q == CW'(WIDTH - 1);
    assign last_word = word_q == WW'(N_WORDS - 1);

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        word_d = word_q;
        case (state_q)
            HUNT: state_d = serial_i == LINE_IDLE ? IDLE : HUNT;
            IDLE: if (enable_i && serial_i == START_BIT) begin
                state_d = DATA;
                bit_d = '0;
                word_d = '0;
            end
            DATA: begin
                // counters return to zero on the final bit so they read 0 in STOP
                bit_d = last_bit ? '0 : bit_q + 1'b1;
                word_d = last_bit ? (last_word ? '0 : word_q + 1'b1) : word_q;
                state_d = last_bit && last_word ? STOP : DATA;
            end
            STOP: state_d = serial_i == STOP_BIT ? IDLE : HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            bit_q <= '0;
            word_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            word_q <= word_d;
            frame_err_q <= state_q == STOP && serial_i != STOP_BIT;
        end
    end

    assign shift_en_o = state_q == DATA;
    assign load_o = state_q == STOP && serial_i == STOP_BIT;
    assign busy_o = state_q == DATA || state_q == STOP;
    assign frame_err_o = frame_err_q;
    assign bit_count_o = bit_q;
    assign word_count_o = word_q;
endmodule

// File: rtl/deserializer_unit_cell.sv
// deserializer_unit_cell: start-bit framed serial receiver with VALID/ACK output
// Ports: CLK, RESET (async high), SERIAL_IN, ENABLE, ACK in;
//        PAR_OUT (word 1 in MSBs), VALID, OVERRUN, FRAME_ERR, BUSY,
//        BIT_COUNT, WORD_COUNT out
module deserializer_unit_cell
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_WORDS = DEF_N_WORDS,
    localparam int CW = $clog2(WIDTH),
    localparam int WW = $clog2(N_WORDS),
    localparam int NB = N_WORDS * WIDTH
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          SERIAL_IN,
    input  logic          ENABLE,
    input  logic          ACK,
    output logic [NB-1:0] PAR_OUT,
    output logic          VALID,
    output logic          OVERRUN,
    output logic          FRAME_ERR,
    output logic          BUSY,
    output logic [CW-1:0] BIT_COUNT,
    output logic [WW-1:0] WORD_COUNT
);
    logic [NB-1:0] sr_q, par_q;
    logic valid_q, valid_d, overrun_q, overrun_d;
    logic shift_en, load;

    deser_frame_ctrl #(.WIDTH(WIDTH), .N_WORDS(N_WORDS), .CW(CW), .WW(WW)) u_ctrl (
        .clk(CLK),
        .rst(RESET),
        .serial_i(SERIAL_IN),
        .enable_i(ENABLE),
        .shift_en_o(shift_en),
        .load_o(load),
        .frame_err_o(FRAME_ERR),
        .busy_o(BUSY),
        .bit_count_o(BIT_COUNT),
        .word_count_o(WORD_COUNT)
    );

    // a load always leaves VALID high; ACK only clears when nothing new arrives
    assign valid_d = load || (valid_q && !ACK);
    // overrun sets only when unconsumed data is replaced without an ACK on that edge
    assign overrun_d = (load && valid_q && !ACK) || (overrun_q && !(valid_q && ACK));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sr_q <= '0;
            par_q <= '0;
            valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (shift_en) sr_q <= {sr_q[NB-2:0], SERIAL_IN};
            if (load) par_q <= sr_q;
            valid_q <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign PAR_OUT = par_q;
    assign VALID = valid_q;
    assign OVERRUN = overrun_q;
endmodule
